// File: rtl/multi_channel_fifo.sv
// Bank of NUM_CHANNELS independent FIFOs sharing one enqueue and one dequeue port.
// Rejected requests leave state untouched and latch sticky per-channel error flags.
module multi_channel_fifo #(
  parameter int unsigned WIDTH                  = 64,
  parameter int unsigned DEPTH                  = 4,
  parameter int unsigned NUM_CHANNELS           = 4,
  parameter int unsigned ALMOST_FULL_THRESHOLD  = DEPTH,
  parameter int unsigned ALMOST_EMPTY_THRESHOLD = 1,
  localparam int unsigned CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_CHANNELS-1:0]       flush_en,
  input  logic                          enqueue_en,
  input  logic [CH_W-1:0]               enqueue_channel,
  input  logic [WIDTH-1:0]              value_i,
  input  logic                          dequeue_en,
  input  logic [CH_W-1:0]               dequeue_channel,
  output logic [WIDTH-1:0]              value_o,
  output logic [NUM_CHANNELS-1:0]       full,
  output logic [NUM_CHANNELS-1:0]       almost_full,
  output logic [NUM_CHANNELS-1:0]       empty,
  output logic [NUM_CHANNELS-1:0]       almost_empty,
  output logic [NUM_CHANNELS*CNT_W-1:0] count,
  output logic [NUM_CHANNELS-1:0]       overflow,
  output logic [NUM_CHANNELS-1:0]       underflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [NUM_CHANNELS][DEPTH];
  logic [PTR_W-1:0] head [NUM_CHANNELS];
  logic [PTR_W-1:0] tail [NUM_CHANNELS];
  logic [CNT_W-1:0] cnt  [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0] enq_hit;
  logic [NUM_CHANNELS-1:0] deq_hit;
  logic [NUM_CHANNELS-1:0] enq_acc;
  logic [NUM_CHANNELS-1:0] deq_acc;
  logic [NUM_CHANNELS-1:0] enq_rej;
  logic [NUM_CHANNELS-1:0] deq_rej;

  // Wrap at DEPTH-1 explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Per-channel accept/reject decode; an out-of-range index matches no channel.
  always_comb begin
    enq_hit = '0;
    deq_hit = '0;
    enq_acc = '0;
    deq_acc = '0;
    enq_rej = '0;
    deq_rej = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      enq_hit[c] = enqueue_en && (enqueue_channel == CH_W'(c)) && !flush_en[c];
      deq_hit[c] = dequeue_en && (dequeue_channel == CH_W'(c)) && !flush_en[c];
      deq_acc[c] = deq_hit[c] && (cnt[c] != '0);
      deq_rej[c] = deq_hit[c] && (cnt[c] == '0);
      enq_acc[c] = enq_hit[c] && ((cnt[c] != CNT_W'(DEPTH)) || deq_acc[c]);
      enq_rej[c] = enq_hit[c] && !enq_acc[c];
    end
  end

  // Pointers, counts and sticky error flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        head[c] <= '0;
        tail[c] <= '0;
        cnt[c]  <= '0;
      end
      overflow  <= '0;
      underflow <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (flush_en[c]) begin
          head[c]      <= '0;
          tail[c]      <= '0;
          cnt[c]       <= '0;
          overflow[c]  <= 1'b0;
          underflow[c] <= 1'b0;
        end else begin
          if (enq_acc[c]) tail[c] <= ptr_inc(tail[c]);
          if (deq_acc[c]) head[c] <= ptr_inc(head[c]);
          case ({enq_acc[c], deq_acc[c]})
            2'b10:   cnt[c] <= cnt[c] + CNT_W'(1);
            2'b01:   cnt[c] <= cnt[c] - CNT_W'(1);
            default: cnt[c] <= cnt[c];
          endcase
          if (enq_rej[c]) overflow[c]  <= 1'b1;
          if (deq_rej[c]) underflow[c] <= 1'b1;
        end
      end
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (reset_n && enq_acc[c]) mem[c][tail[c]] <= value_i;
    end
  end

  // Show-ahead read of the selected channel's head entry.
  always_comb begin
    value_o = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (dequeue_channel == CH_W'(c)) value_o = mem[c][head[c]];
    end
  end

  // Status flags decoded from registered counts.
  always_comb begin
    full         = '0;
    almost_full  = '0;
    empty        = '0;
    almost_empty = '0;
    count        = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      full[c]                 = (cnt[c] == CNT_W'(DEPTH));
      almost_full[c]          = (cnt[c] >= CNT_W'(ALMOST_FULL_THRESHOLD));
      empty[c]                = (cnt[c] == '0);
      almost_empty[c]         = (cnt[c] <= CNT_W'(ALMOST_EMPTY_THRESHOLD));
      count[c*CNT_W +: CNT_W] = cnt[c];
    end
  end

  // Requests naming a channel that does not exist are a usage error.
  always_ff @(posedge clk) begin
    if (reset_n && enqueue_en) assert (32'(enqueue_channel) < NUM_CHANNELS);
    if (reset_n && dequeue_en) assert (32'(dequeue_channel) < NUM_CHANNELS);
  end

endmodule

// File: tb/tb_multi_channel_fifo.sv
// Directed scoreboard bench for multi_channel_fifo: a 4x4 bank and a 1x5 instance
// that exercises non-power-of-two pointer wrap.
module tb_multi_channel_fifo;

  logic        clk = 1'b0;
  logic        reset_n;
  always #5 clk = ~clk;

  // 4 channels x 4 entries
  logic [3:0]  flush_en;
  logic        enq_en;
  logic [1:0]  enq_ch;
  logic [63:0] val_i;
  logic        deq_en;
  logic [1:0]  deq_ch;
  logic [63:0] val_o;
  logic [3:0]  full, almost_full, empty, almost_empty, overflow, underflow;
  logic [11:0] count;

  // 1 channel x 5 entries
  logic        b_flush;
  logic        b_enq_en;
  logic        b_ch;
  logic [63:0] b_val_i;
  logic        b_deq_en;
  logic [63:0] b_val_o;
  logic        b_full, b_afull, b_empty, b_aempty, b_ovf, b_udf;
  logic [2:0]  b_count;

  multi_channel_fifo dut (
    .clk(clk), .reset_n(reset_n), .flush_en(flush_en),
    .enqueue_en(enq_en), .enqueue_channel(enq_ch), .value_i(val_i),
    .dequeue_en(deq_en), .dequeue_channel(deq_ch), .value_o(val_o),
    .full(full), .almost_full(almost_full), .empty(empty),
    .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  multi_channel_fifo #(.DEPTH(5), .NUM_CHANNELS(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .flush_en(b_flush),
    .enqueue_en(b_enq_en), .enqueue_channel(b_ch), .value_i(b_val_i),
    .dequeue_en(b_deq_en), .dequeue_channel(b_ch), .value_o(b_val_o),
    .full(b_full), .almost_full(b_afull), .empty(b_empty),
    .almost_empty(b_aempty), .count(b_count),
    .overflow(b_ovf), .underflow(b_udf)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] sb [4][$];
  logic [63:0] sb_b [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model_count();
    logic [11:0] m = '0;
    for (int c = 0; c < 4; c++) m[c*3 +: 3] = 3'(sb[c].size());
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush_en = '0; enq_en = 1'b0; enq_ch = '0; val_i = '0; deq_en = 1'b0; deq_ch = '0;
    b_flush = 1'b0; b_enq_en = 1'b0; b_ch = 1'b0; b_val_i = '0; b_deq_en = 1'b0;
  endtask

  task automatic push(input int ch, input logic [63:0] v);
    enq_en = 1'b1; enq_ch = 2'(ch); val_i = v;
    sb[ch].push_back(v);
    tick();
    idle();
  endtask

  task automatic pop(input int ch, input string tag);
    logic [63:0] exp;
    deq_en = 1'b1; deq_ch = 2'(ch);
    #1;
    exp = sb[ch].pop_front();
    check(tag, val_o, exp);
    tick();
    idle();
  endtask

  task automatic b_push(input logic [63:0] v);
    b_enq_en = 1'b1; b_val_i = v;
    sb_b.push_back(v);
    tick();
    idle();
  endtask

  task automatic b_pop(input string tag);
    logic [63:0] exp;
    b_deq_en = 1'b1;
    #1;
    exp = sb_b.pop_front();
    check(tag, b_val_o, exp);
    tick();
    idle();
  endtask

  initial begin
    logic [63:0] exp;
    idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    check("rst_empty", 64'(empty), 64'hF);
    check("rst_aempty", 64'(almost_empty), 64'hF);
    check("rst_full", 64'(full), 64'h0);
    check("rst_afull", 64'(almost_full), 64'h0);
    check("rst_count", 64'(count), 64'h0);
    check("rst_errs", 64'({overflow, underflow}), 64'h0);
    check("rst_b_empty", 64'(b_empty), 64'h1);

    // DEPTH=5 single channel: steady pairs walk both pointers across the wrap
    for (int i = 0; i < 3; i++) b_push(64'h100 + 64'(i));
    for (int i = 0; i < 12; i++) begin
      b_enq_en = 1'b1; b_deq_en = 1'b1; b_val_i = 64'h200 + 64'(i);
      #1;
      exp = sb_b.pop_front();
      check("wrap_data", b_val_o, exp);
      sb_b.push_back(b_val_i);
      tick();
      idle();
      check("wrap_count", 64'(b_count), 64'(sb_b.size()));
    end
    b_push(64'h300);
    b_push(64'h301);
    check("b_full", 64'(b_full), 64'h1);
    check("b_count5", 64'(b_count), 64'd5);
    b_enq_en = 1'b1; b_val_i = 64'h3FF;
    tick();
    idle();
    check("b_ovf", 64'(b_ovf), 64'h1);
    check("b_count_cap", 64'(b_count), 64'd5);
    for (int i = 0; i < 5; i++) b_pop("b_drain");
    check("b_empty_end", 64'(b_empty), 64'h1);

    // fill ch1, then drain in order
    for (int i = 0; i < 4; i++) push(1, 64'hA0 + 64'(i));
    check("t1_full", 64'(full), 64'b0010);
    check("t1_afull", 64'(almost_full), 64'b0010);
    check("t1_count", 64'(count), 64'(model_count()));
    check("t1_empty", 64'(empty), 64'b1101);
    for (int i = 0; i < 4; i++) pop(1, "t1_data");
    check("t1_drained", 64'(empty), 64'hF);

    // overflow on full ch2, then full-channel enqueue+dequeue accepted
    for (int i = 0; i < 4; i++) push(2, 64'h20 + 64'(i));
    enq_en = 1'b1; enq_ch = 2'd2; val_i = 64'h55;
    tick();
    idle();
    check("t3_ovf", 64'(overflow), 64'b0100);
    check("t3_count", 64'(count), 64'(model_count()));
    enq_en = 1'b1; enq_ch = 2'd2; val_i = 64'h66; deq_en = 1'b1; deq_ch = 2'd2;
    #1;
    exp = sb[2].pop_front();
    check("t3_pair_data", val_o, exp);
    sb[2].push_back(64'h66);
    tick();
    idle();
    check("t3_pair_count", 64'(count[6 +: 3]), 64'd4);
    for (int i = 0; i < 4; i++) pop(2, "t3_drain");

    // underflow with concurrent enqueue to the same empty channel
    enq_en = 1'b1; enq_ch = 2'd0; val_i = 64'h77; deq_en = 1'b1; deq_ch = 2'd0;
    sb[0].push_back(64'h77);
    tick();
    idle();
    check("t4_udf", 64'(underflow), 64'b0001);
    check("t4_count", 64'(count), 64'(model_count()));
    #1;
    check("t4_head", val_o, 64'h77);
    pop(0, "t4_pop");

    // flush ch3 (3 entries, overflow set) alongside an enqueue to ch3
    for (int i = 0; i < 4; i++) push(3, 64'h30 + 64'(i));
    enq_en = 1'b1; enq_ch = 2'd3; val_i = 64'h3F;
    tick();
    idle();
    pop(3, "t5_pop");
    push(0, 64'h01);
    push(0, 64'h02);
    check("t5_pre_ovf", 64'(overflow), 64'b1100);
    flush_en = 4'b1000; enq_en = 1'b1; enq_ch = 2'd3; val_i = 64'h99;
    sb[3].delete();
    tick();
    idle();
    check("t5_count", 64'(count), 64'(model_count()));
    check("t5_ovf", 64'(overflow), 64'b0100);
    check("t5_udf", 64'(underflow), 64'b0001);
    check("t5_empty", 64'(empty), 64'b1110);
    push(3, 64'hB0);
    deq_ch = 2'd3;
    #1;
    check("t5_head_reset", val_o, 64'hB0);

    // enqueue and dequeue on different channels in the same cycle
    enq_en = 1'b1; enq_ch = 2'd1; val_i = 64'hC1; deq_en = 1'b1; deq_ch = 2'd0;
    #1;
    exp = sb[0].pop_front();
    check("xch_data", val_o, exp);
    sb[1].push_back(64'hC1);
    tick();
    idle();
    check("xch_count", 64'(count), 64'(model_count()));

    // reset pulse between edges is not sampled
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    tick();
    check("async_pulse", 64'(count), 64'(model_count()));
    check("async_errs", 64'({overflow, underflow}), 64'h41);

    // synchronous reset mid-traffic
    reset_n = 1'b0; enq_en = 1'b1; enq_ch = 2'd0; val_i = 64'hEE; deq_en = 1'b1; deq_ch = 2'd1;
    tick();
    reset_n = 1'b1;
    idle();
    for (int c = 0; c < 4; c++) sb[c].delete();
    check("srst_count", 64'(count), 64'h0);
    check("srst_errs", 64'({overflow, underflow}), 64'h0);
    check("srst_empty", 64'(empty), 64'hF);
    check("srst_b_empty", 64'(b_empty), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
